// File: rtl/gaplus_dl_pkg.sv
// Gaplus ROM map constants, FSM states and address classes.
// Shared by the download controller and its region decoder.
package gaplus_dl_pkg;

  localparam logic [17:0] MAIN_BASE = 18'h00000;
  localparam logic [17:0] MAIN_LIM  = 18'h05FFF;
  localparam logic [17:0] SUB_BASE  = 18'h08000;
  localparam logic [17:0] SUB_LIM   = 18'h0DFFF;
  localparam logic [17:0] BG_BASE   = 18'h0E000;
  localparam logic [17:0] BG_LIM    = 18'h0FFFF;
  localparam logic [17:0] SPR_BASE  = 18'h10000;
  localparam logic [17:0] SPR_LIM   = 18'h17FFF;
  localparam logic [17:0] CLUT_BASE = 18'h20000;
  localparam logic [17:0] CLUT_LIM  = 18'h203FF;
  localparam logic [17:0] PAL_BASE  = 18'h20500;
  localparam logic [17:0] PAL_LIM   = 18'h207FF;
  localparam logic [17:0] MAP_END   = 18'h20800;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN,
    ERR
  } dl_state_e;

  typedef enum logic [1:0] {
    LEGAL,
    PAD,
    OOB
  } dl_class_e;

  function automatic logic in_rng(
    input logic [17:0] a,
    input logic [17:0] lo,
    input logic [17:0] hi
  );
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/dl_region_decode.sv
// Combinational classifier of a download byte offset
// against the Gaplus ROM map.
import gaplus_dl_pkg::*;

module dl_region_decode (
  input  logic [24:0] addr,
  output dl_class_e   cls
);

  logic [17:0] a;
  logic        hi_set;
  logic        legal;

  assign a      = addr[17:0];
  assign hi_set = |addr[24:18];

  assign legal = in_rng(a, MAIN_BASE, MAIN_LIM)
               | in_rng(a, SUB_BASE, SUB_LIM)
               | in_rng(a, BG_BASE, BG_LIM)
               | in_rng(a, SPR_BASE, SPR_LIM)
               | in_rng(a, CLUT_BASE, CLUT_LIM)
               | in_rng(a, PAL_BASE, PAL_LIM);

  always_comb begin
    cls = PAD;
    if (hi_set || (a >= MAP_END)) begin
      cls = OOB;
    end else if (legal) begin
      cls = LEGAL;
    end
  end

endmodule

// File: rtl/rom_download_ctrl.sv
// ioctl byte stream to ROM write bus, load check and CPU reset hold.
// ROMDL_CHECKSUM_EN adds a 16-bit sum of accepted bytes.
import gaplus_dl_pkg::*;

module rom_download_ctrl #(
  parameter logic [7:0]  ROM_INDEX    = 8'h00,
  parameter logic [17:0] EXPECT_BYTES = 18'd91904,
  parameter logic [15:0] HOLD_CYC     = 16'd1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dl_active,
  input  logic [7:0]  dl_index,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        ROMCL,
  output logic [17:0] ROMAD,
  output logic [7:0]  ROMDT,
  output logic        ROMEN,
  output logic        cpu_rst,
  output logic        load_done,
  output logic        err_oob,
  output logic        err_short,
  output logic [17:0] byte_cnt,
  output logic [15:0] checksum
);

  dl_state_e   state_q, state_d;
  logic [17:0] romad_q, romad_d;
  logic [7:0]  romdt_q, romdt_d;
  logic        romen_q, romen_d;
  logic [17:0] cnt_q, cnt_d;
  logic        oob_q, oob_d;
  logic        short_q, short_d;
  logic [15:0] hold_q, hold_d;
  logic        enter_load;
  logic        accept;
  logic        sel;
  dl_class_e   cls;

  dl_region_decode u_dec (
    .addr (dl_addr),
    .cls  (cls)
  );

  assign sel = (dl_index == ROM_INDEX);

  always_comb begin
    state_d    = state_q;
    romad_d    = romad_q;
    romdt_d    = romdt_q;
    romen_d    = 1'b0;
    cnt_d      = cnt_q;
    oob_d      = oob_q;
    short_d    = short_q;
    hold_d     = hold_q;
    enter_load = 1'b0;
    accept     = 1'b0;
    case (state_q)
      LOAD: begin
        if (sel) begin
          if (dl_wr && (cls == LEGAL)) begin
            accept  = 1'b1;
            romen_d = 1'b1;
            romad_d = dl_addr[17:0];
            romdt_d = dl_data;
            if (cnt_q != '1) cnt_d = cnt_q + 18'd1;
          end else if (dl_wr && (cls == OOB)) begin
            oob_d = 1'b1;
          end
          // the closing write is already folded into cnt_d/oob_d
          if (!dl_active) begin
            if (!oob_d && (cnt_d == EXPECT_BYTES)) begin
              state_d = HOLD;
              hold_d  = HOLD_CYC - 16'd1;
            end else begin
              state_d = ERR;
              short_d = (cnt_d != EXPECT_BYTES);
            end
          end
        end
      end
      default: begin
        if (state_q == HOLD) begin
          if (hold_q == 16'd0) state_d = RUN;
          else hold_d = hold_q - 16'd1;
        end
        if (sel && dl_active) begin
          enter_load = 1'b1;
          state_d    = LOAD;
          cnt_d      = '0;
          oob_d      = 1'b0;
          short_d    = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      romad_q <= '0;
      romdt_q <= '0;
      romen_q <= 1'b0;
      cnt_q   <= '0;
      oob_q   <= 1'b0;
      short_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      romad_q <= romad_d;
      romdt_q <= romdt_d;
      romen_q <= romen_d;
      cnt_q   <= cnt_d;
      oob_q   <= oob_d;
      short_q <= short_d;
      hold_q  <= hold_d;
    end
  end

`ifdef ROMDL_CHECKSUM_EN
  logic [15:0] cks_q, cks_d;

  always_comb begin
    cks_d = cks_q;
    if (enter_load) cks_d = '0;
    else if (accept) cks_d = cks_q + {8'h00, dl_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cks_q <= '0;
    else       cks_q <= cks_d;
  end

  assign checksum = cks_q;
`else
  logic unused_cks;
  assign unused_cks = enter_load ^ accept;
  assign checksum   = 16'h0000;
`endif

  assign ROMCL     = clk;
  assign ROMAD     = romad_q;
  assign ROMDT     = romdt_q;
  assign ROMEN     = romen_q;
  assign byte_cnt  = cnt_q;
  assign err_oob   = oob_q;
  assign err_short = short_q;
  assign cpu_rst   = (state_q != RUN);
  assign load_done = (state_q == RUN);

endmodule

// File: tb/tb_rom_download_ctrl.sv
// Scoreboard bench for rom_download_ctrl: queued ROM writes
// are checked by a ROMEN monitor; status checked inline.
module tb_rom_download_ctrl;

  localparam logic [17:0] TB_EXP = 18'd212;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dl_active = 1'b0;
  logic [7:0]  dl_index = 8'h00;
  logic        dl_wr = 1'b0;
  logic [24:0] dl_addr = '0;
  logic [7:0]  dl_data = '0;
  logic        ROMCL;
  logic [17:0] ROMAD;
  logic [7:0]  ROMDT;
  logic        ROMEN;
  logic        cpu_rst;
  logic        load_done;
  logic        err_oob;
  logic        err_short;
  logic [17:0] byte_cnt;
  logic [15:0] checksum;

  int n_vec = 0;
  int n_err = 0;
  int n_push = 0;
  int n_pop = 0;
  logic [25:0] exp_q[$];

  rom_download_ctrl #(
    .EXPECT_BYTES (TB_EXP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dl_active (dl_active),
    .dl_index  (dl_index),
    .dl_wr     (dl_wr),
    .dl_addr   (dl_addr),
    .dl_data   (dl_data),
    .ROMCL     (ROMCL),
    .ROMAD     (ROMAD),
    .ROMDT     (ROMDT),
    .ROMEN     (ROMEN),
    .cpu_rst   (cpu_rst),
    .load_done (load_done),
    .err_oob   (err_oob),
    .err_short (err_short),
    .byte_cnt  (byte_cnt),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && ROMEN) begin
      logic [25:0] e;
      n_pop++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_romen got %h/%h want none",
                 ROMAD, ROMDT);
      end else begin
        e = exp_q.pop_front();
        if ({ROMAD, ROMDT} !== e) begin
          n_err++;
          $display("FAIL rom_write got %h/%h want %h/%h",
                   ROMAD, ROMDT, e[25:8], e[7:0]);
        end
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s got %h want %h", nm, act, req);
    end
  endtask

  task automatic wr(input logic [24:0] a,
                    input logic [7:0] d,
                    input bit ex);
    dl_wr   = 1'b1;
    dl_addr = a;
    dl_data = d;
    if (ex) begin
      exp_q.push_back({a[17:0], d});
      n_push++;
    end
    @(posedge clk);
    #1;
    dl_wr = 1'b0;
  endtask

  task automatic start_dl();
    dl_index  = 8'h00;
    dl_active = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic stop_dl();
    dl_active = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // HOLD was entered at the last edge; RUN after 1024 more
  task automatic wait_hold();
    repeat (1023) @(posedge clk);
    #1;
    chk("hold_cpu_rst_end", cpu_rst, 1);
    @(posedge clk);
    #1;
    chk("run_cpu_rst", cpu_rst, 0);
    chk("run_load_done", load_done, 1);
  endtask

  typedef struct {
    logic [24:0] a;
    bit          ex;
  } vec_t;

  vec_t edges[18] = '{
    '{25'h00000, 1}, '{25'h05FFF, 1}, '{25'h06000, 0},
    '{25'h07FFF, 0}, '{25'h08000, 1}, '{25'h0DFFF, 1},
    '{25'h0E000, 1}, '{25'h0FFFF, 1}, '{25'h10000, 1},
    '{25'h17FFF, 1}, '{25'h18000, 0}, '{25'h1FFFF, 0},
    '{25'h20000, 1}, '{25'h203FF, 1}, '{25'h20400, 0},
    '{25'h204FF, 0}, '{25'h20500, 1}, '{25'h207FF, 1}
  };

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_romad", ROMAD, 0);
    chk("rst_romdt", ROMDT, 0);
    chk("rst_romen", ROMEN, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_load_done", load_done, 0);
    chk("rst_err_oob", err_oob, 0);
    chk("rst_err_short", err_short, 0);
    chk("rst_byte_cnt", byte_cnt, 0);
    chk("rst_checksum", checksum, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // full load: region edges, a main block, 0x2000 pad bytes
    start_dl();
    chk("load_cpu_rst", cpu_rst, 1);
    foreach (edges[i]) wr(edges[i].a, 8'hA0 + 8'(i), edges[i].ex);
    for (int i = 0; i < 200; i++) wr(25'h00100 + 25'(i), 8'(i), 1);
    for (int i = 0; i < 8192; i++) wr(25'h06000 + 25'(i), 8'h33, 0);
    chk("full_cnt_pre", byte_cnt, 212);
    stop_dl();
    chk("full_err_oob", err_oob, 0);
    chk("full_err_short", err_short, 0);
    chk("full_hold_load_done", load_done, 0);
    wait_hold();

    // foreign index while running
    dl_index  = 8'h01;
    dl_active = 1'b1;
    wr(25'h00010, 8'h77, 0);
    wr(25'h08010, 8'h78, 0);
    wr(25'h10010, 8'h79, 0);
    @(posedge clk);
    #1;
    chk("foreign_load_done", load_done, 1);
    chk("foreign_cpu_rst", cpu_rst, 0);
    chk("foreign_cnt", byte_cnt, 212);
    dl_active = 1'b0;
    @(posedge clk);
    #1;

    // latency, pad suppression, OOB
    start_dl();
    chk("reload_load_done", load_done, 0);
    chk("reload_cpu_rst", cpu_rst, 1);
    chk("reload_cnt", byte_cnt, 0);
    wr(25'h0E123, 8'h5A, 1);
    chk("lat_romen", ROMEN, 1);
    chk("lat_romad", ROMAD, 32'h0E123);
    chk("lat_romdt", ROMDT, 32'h5A);
    wr(25'h06000, 8'h11, 0);
    chk("pad_romen", ROMEN, 0);
    chk("pad_romad_hold", ROMAD, 32'h0E123);
    chk("pad_cnt", byte_cnt, 1);
    chk("pad_err_oob", err_oob, 0);
    wr(25'h20800, 8'h22, 0);
    chk("oob_romen", ROMEN, 0);
    chk("oob_err", err_oob, 1);
    wr(25'h1000000, 8'h23, 0);
    chk("oob_hi_romen", ROMEN, 0);
    stop_dl();
    chk("err_cpu_rst", cpu_rst, 1);
    chk("err_load_done", load_done, 0);
    chk("err_short_mismatch", err_short, 1);
    repeat (20) @(posedge clk);
    #1;
    chk("err_stays_cpu_rst", cpu_rst, 1);

    // short load
    start_dl();
    chk("new_dl_clr_oob", err_oob, 0);
    chk("new_dl_clr_short", err_short, 0);
    for (int i = 0; i < 211; i++) wr(25'h08000 + 25'(i), 8'(i), 1);
    stop_dl();
    chk("short_cnt", byte_cnt, 211);
    chk("short_err", err_short, 1);
    chk("short_load_done", load_done, 0);

    // last byte coincident with dl_active falling
    start_dl();
    for (int i = 0; i < 211; i++) wr(25'h10000 + 25'(i), 8'(i), 1);
    dl_active = 1'b0;
    wr(25'h207FF, 8'hEE, 1);
    chk("coin_cnt", byte_cnt, 212);
    chk("coin_err_short", err_short, 0);
    chk("coin_cpu_rst", cpu_rst, 1);
    wait_hold();

    // checksum, then reset at byte 500
    start_dl();
    wr(25'h10000, 8'h01, 1);
    wr(25'h10001, 8'hFF, 1);
    wr(25'h10002, 8'h80, 1);
    chk("cks_cnt", byte_cnt, 3);
`ifdef ROMDL_CHECKSUM_EN
    chk("checksum", checksum, 32'h0180);
`else
    chk("checksum_off", checksum, 0);
`endif
    for (int i = 3; i < 500; i++) wr(25'h10000 + 25'(i), 8'(i), 1);
    chk("mid_cnt", byte_cnt, 500);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mrst_romad", ROMAD, 0);
    chk("mrst_romdt", ROMDT, 0);
    chk("mrst_romen", ROMEN, 0);
    chk("mrst_cpu_rst", cpu_rst, 1);
    chk("mrst_load_done", load_done, 0);
    chk("mrst_cnt", byte_cnt, 0);
    chk("mrst_checksum", checksum, 0);
    dl_active = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_cpu_rst", cpu_rst, 1);
    chk("sb_empty", exp_q.size(), 0);
    chk("romen_pulses", n_pop, n_push);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
